// File: rtl/spi_master_sequencer_if.sv
// Host-side request/response and SPI pin bundle for spi_master_sequencer.
// Start is a level request with no ready: the sequencer samples it only while idle, and Busy/Done report progress.
interface spi_master_sequencer_if #(
  parameter int FRAME_BITS = 16
);
  logic                  Start;
  logic [1:0]            SelectMode;
  logic [FRAME_BITS-1:0] TxData;
  logic                  MISO;
  logic                  Busy;
  logic                  Done;
  logic [FRAME_BITS-1:0] RxData;
  logic                  SS_n;
  logic                  SCLK;
  logic                  MOSI;

  modport master (
    input  Start, SelectMode, TxData, MISO,
    output Busy, Done, RxData, SS_n, SCLK, MOSI
  );

  modport slave (
    output Start, SelectMode, TxData, MISO,
    input  Busy, Done, RxData, SS_n, SCLK, MOSI
  );
endinterface

// File: rtl/spi_master_sequencer.sv
// Single-frame SPI master sequencer: IDLE -> SETUP -> XFER -> HOLD, in any of the four SPI modes.
// All pin outputs are registered, so SCLK, SS_n and MOSI are glitch-free.
module spi_master_sequencer #(
  parameter int FRAME_BITS = 16,
  parameter int CLK_DIV    = 2
) (
  input  logic                   clk,
  input  logic                   Reset,
  spi_master_sequencer_if.master bus,
  output logic [1:0]             dbg_state
);
  localparam int EW = $clog2(2 * FRAME_BITS);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [EW-1:0] EDGE_LAST = EW'(2 * FRAME_BITS - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  logic [1:0]            state;
  logic [DW-1:0]         div_cnt;
  logic [EW-1:0]         edge_cnt;
  logic [1:0]            mode_q;
  logic [FRAME_BITS-1:0] tx_sr;
  logic [FRAME_BITS-1:0] rx_sr;
  logic [FRAME_BITS-1:0] rx_data_q;
  logic                  busy_q, done_q, ss_n_q, sclk_q, mosi_q;

  logic                  div_tick, edge_go, edge_lead, edge_shift, edge_sample;
  logic [EW-1:0]         edge_idx;

  // edge_cnt holds the index of the last SCLK edge issued; the tick after the
  // final edge spends the trailing half-period before HOLD begins.
  always_comb begin
    div_tick    = (div_cnt == DIV_LAST);
    edge_idx    = (state == ST_SETUP) ? '0 : edge_cnt + 1'b1;
    edge_go     = div_tick &&
                  ((state == ST_SETUP) || ((state == ST_XFER) && (edge_cnt != EDGE_LAST)));
    edge_lead   = ~edge_idx[0];
    edge_shift  = mode_q[0] ? edge_lead : (!edge_lead && (edge_idx != EDGE_LAST));
    edge_sample = mode_q[0] ? !edge_lead : edge_lead;
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state     <= ST_IDLE;
      div_cnt   <= '0;
      edge_cnt  <= '0;
      mode_q    <= 2'd0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      rx_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ss_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      div_cnt <= ((state == ST_IDLE) || div_tick) ? '0 : div_cnt + 1'b1;

      case (state)
        ST_IDLE: begin
          sclk_q <= mode_q[1];
          mosi_q <= 1'b0;
          if (bus.Start) begin
            mode_q   <= bus.SelectMode;
            sclk_q   <= bus.SelectMode[1];
            ss_n_q   <= 1'b0;
            busy_q   <= 1'b1;
            edge_cnt <= '0;
            state    <= ST_SETUP;
            // CPHA=0 presents the MSB before the first edge; CPHA=1 waits for it.
            if (bus.SelectMode[0]) begin
              tx_sr  <= bus.TxData;
              mosi_q <= 1'b0;
            end else begin
              tx_sr  <= bus.TxData << 1;
              mosi_q <= bus.TxData[FRAME_BITS-1];
            end
          end
        end
        ST_SETUP: begin
          if (div_tick) state <= ST_XFER;
        end
        ST_XFER: begin
          if (div_tick && (edge_cnt == EDGE_LAST)) state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (div_tick) begin
            ss_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            rx_data_q <= rx_sr;
            mosi_q    <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (edge_go) begin
        sclk_q   <= ~sclk_q;
        edge_cnt <= edge_idx;
        if (edge_shift) begin
          mosi_q <= tx_sr[FRAME_BITS-1];
          tx_sr  <= tx_sr << 1;
        end
        if (edge_sample) rx_sr <= {rx_sr[FRAME_BITS-2:0], bus.MISO};
      end
    end
  end

  assign bus.Busy   = busy_q;
  assign bus.Done   = done_q;
  assign bus.RxData = rx_data_q;
  assign bus.SS_n   = ss_n_q;
  assign bus.SCLK   = sclk_q;
  assign bus.MOSI   = mosi_q;
  assign dbg_state  = state;
endmodule

// File: tb/tb_spi_master_sequencer.sv
// Bench for spi_master_sequencer: three parameterisations behind one observation mux,
// a behavioural SPI slave, and frame-level timing/data expectations.
module tb_spi_master_sequencer;
  logic        clk = 1'b0;
  logic        Reset;
  logic        start;
  int          sel;
  logic [1:0]  mode_in;
  logic [31:0] tx;
  logic [31:0] slv_word;
  logic [1:0]  slv_mode;
  logic        loop;
  logic        miso;
  logic [1:0]  dbg0, dbg1, dbg2;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  spi_master_sequencer_if #(.FRAME_BITS(16)) if0();
  spi_master_sequencer_if #(.FRAME_BITS(8))  if1();
  spi_master_sequencer_if #(.FRAME_BITS(16)) if2();

  spi_master_sequencer #(.FRAME_BITS(16), .CLK_DIV(2)) u0 (.clk(clk), .Reset(Reset), .bus(if0.master), .dbg_state(dbg0));
  spi_master_sequencer #(.FRAME_BITS(8),  .CLK_DIV(3)) u1 (.clk(clk), .Reset(Reset), .bus(if1.master), .dbg_state(dbg1));
  spi_master_sequencer #(.FRAME_BITS(16), .CLK_DIV(1)) u2 (.clk(clk), .Reset(Reset), .bus(if2.master), .dbg_state(dbg2));

  function automatic int fb_of(input int s);
    return (s == 1) ? 8 : 16;
  endfunction

  function automatic int cd_of(input int s);
    return (s == 1) ? 3 : ((s == 2) ? 1 : 2);
  endfunction

  assign if0.Start = start && (sel == 0);
  assign if1.Start = start && (sel == 1);
  assign if2.Start = start && (sel == 2);
  assign if0.SelectMode = mode_in;
  assign if1.SelectMode = mode_in;
  assign if2.SelectMode = mode_in;
  assign if0.TxData = tx[15:0];
  assign if1.TxData = tx[7:0];
  assign if2.TxData = tx[15:0];
  assign if0.MISO = miso;
  assign if1.MISO = miso;
  assign if2.MISO = miso;

  logic busy_m, done_m, ss_n_m, sclk_m, mosi_m;
  logic [31:0] rx_m;
  always_comb begin
    busy_m = 1'b0; done_m = 1'b0; ss_n_m = 1'b1; sclk_m = 1'b0; mosi_m = 1'b0; rx_m = '0;
    case (sel)
      0: begin busy_m = if0.Busy; done_m = if0.Done; ss_n_m = if0.SS_n; sclk_m = if0.SCLK; mosi_m = if0.MOSI; rx_m = {16'd0, if0.RxData}; end
      1: begin busy_m = if1.Busy; done_m = if1.Done; ss_n_m = if1.SS_n; sclk_m = if1.SCLK; mosi_m = if1.MOSI; rx_m = {24'd0, if1.RxData}; end
      default: begin busy_m = if2.Busy; done_m = if2.Done; ss_n_m = if2.SS_n; sclk_m = if2.SCLK; mosi_m = if2.MOSI; rx_m = {16'd0, if2.RxData}; end
    endcase
  end

  // Behavioural SPI slave plus frame statistics, sampled on the falling clk edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        ss_n_prev = 1'b1, sclk_prev = 1'b0, busy_prev = 1'b0, slv_miso = 1'b0;
  logic [1:0]  s_mode = 2'd0;
  logic [31:0] s_tx = '0, s_rx = '0, slv_js;
  int          frames = 0, ss_lo_cnt = 0, busy_hi_cnt = 0, busy_falls = 0;
  int          lead_cnt = 0, gap_len = 0, last_gap = 0;
  logic [31:0] slv_rx_arr [64];
  int          lead_arr [64];
  logic        s_lead;

  assign slv_js = slv_word << (32 - fb_of(sel));
  assign s_lead = (sclk_m != s_mode[1]);
  assign miso   = loop ? mosi_m : slv_miso;

  always @(negedge clk) begin
    ss_n_prev <= ss_n_m;
    sclk_prev <= sclk_m;
    busy_prev <= busy_m;
    if (busy_m) busy_hi_cnt <= busy_hi_cnt + 1;
    if (busy_prev && !busy_m) busy_falls <= busy_falls + 1;
    if (ss_n_m) gap_len <= gap_len + 1;
    else begin
      ss_lo_cnt <= ss_lo_cnt + 1;
      gap_len   <= 0;
    end
    if (ss_n_prev && !ss_n_m) begin
      last_gap <= gap_len;
      s_mode   <= slv_mode;
      s_rx     <= '0;
      lead_cnt <= 0;
      if (slv_mode[0]) begin
        s_tx     <= slv_js;
        slv_miso <= 1'b0;
      end else begin
        s_tx     <= slv_js << 1;
        slv_miso <= slv_js[31];
      end
    end else if (!ss_n_prev && !ss_n_m && (sclk_m != sclk_prev)) begin
      if (s_lead) lead_cnt <= lead_cnt + 1;
      if (s_lead == s_mode[0]) begin
        slv_miso <= s_tx[31];
        s_tx     <= s_tx << 1;
      end else begin
        s_rx <= {s_rx[30:0], mosi_m};
      end
    end
    if (!ss_n_prev && ss_n_m) begin
      slv_rx_arr[frames % 64] <= s_rx;
      lead_arr[frames % 64]   <= lead_cnt;
      frames <= frames + 1;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One complete frame; pa/pb are cycle offsets from accept for ignored Start pulses (0 = none).
  task automatic run_frame(input int s, input logic [1:0] mode, input logic [31:0] tx_w,
                           input logic [31:0] slave_w, input logic lb, input int pa, input int pb,
                           input string tag);
    int f, d, t0, fr0, ss0, bz0, bf0, span;
    bit ok;
    logic [31:0] mask, exp_rx;
    f = fb_of(s);
    d = cd_of(s);
    span = d * (2 * f + 2);
    mask = (32'd1 << f) - 32'd1;
    sel = s; mode_in = mode; tx = tx_w; slv_word = slave_w; slv_mode = mode; loop = lb;
    exp_q.push_back(lb ? (tx_w & mask) : (slave_w & mask));
    step();
    fr0 = frames; ss0 = ss_lo_cnt; bz0 = busy_hi_cnt; bf0 = busy_falls;
    start = 1'b1;
    step();
    start = 1'b0;
    t0 = cyc;
    check({tag, ".busy_t0"}, 32'(busy_m), 32'd1);
    check({tag, ".ss_n_t0"}, 32'(ss_n_m), 32'd0);
    check({tag, ".sclk_t0"}, 32'(sclk_m), 32'(mode[1]));
    tx = $urandom;
    mode_in = 2'($urandom_range(0, 3));
    ok = 0;
    for (int i = 0; i < span + 10; i++) begin
      step();
      start = ((pa != 0) && (cyc - t0 == pa - 1)) || ((pb != 0) && (cyc - t0 == pb - 1));
      if (done_m) begin
        ok = 1;
        break;
      end
    end
    start = 1'b0;
    check({tag, ".done_seen"}, 32'(ok), 32'd1);
    exp_rx = exp_q.pop_front();
    if (ok) begin
      check({tag, ".latency"}, 32'(cyc - t0), 32'(span));
      check({tag, ".busy_at_done"}, 32'(busy_m), 32'd0);
      check({tag, ".rx"}, rx_m, exp_rx);
      step();
      check({tag, ".done_width"}, 32'(done_m), 32'd0);
      check({tag, ".no_requeue"}, 32'(busy_m), 32'd0);
      check({tag, ".ss_low_len"}, 32'(ss_lo_cnt - ss0), 32'(span));
      check({tag, ".busy_len"}, 32'(busy_hi_cnt - bz0), 32'(span));
      check({tag, ".busy_falls"}, 32'(busy_falls - bf0), 32'd1);
      check({tag, ".frames"}, 32'(frames - fr0), 32'd1);
      check({tag, ".mosi_word"}, slv_rx_arr[fr0 % 64], tx_w & mask);
      check({tag, ".lead_edges"}, 32'(lead_arr[fr0 % 64]), 32'(f));
      check({tag, ".sclk_idle"}, 32'(sclk_m), 32'(mode[1]));
    end
  endtask

  int t0, d1, d2, fr0;
  bit ok;

  initial begin
    Reset = 1'b1; start = 1'b0; sel = 0; mode_in = 2'd0; tx = '0;
    slv_word = '0; slv_mode = 2'd0; loop = 1'b0;
    step(); step(); step();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check("reset.busy", 32'(busy_m), 32'd0);
      check("reset.done", 32'(done_m), 32'd0);
      check("reset.ss_n", 32'(ss_n_m), 32'd1);
      check("reset.sclk", 32'(sclk_m), 32'd0);
      check("reset.mosi", 32'(mosi_m), 32'd0);
      check("reset.rx",   rx_m, 32'd0);
    end
    Reset = 1'b0;
    step();

    run_frame(0, 2'd0, 32'hA5C3, 32'h0, 1'b1, 0, 0, "m0_loop");
    run_frame(0, 2'd3, 32'hFFFF, 32'h1234, 1'b0, 0, 0, "m3_slave");
    run_frame(0, 2'd1, 32'h3C5A, 32'h8001, 1'b0, 10, 30, "m1_ignore");

    // Asynchronous reset in the middle of a mode 2 frame.
    sel = 0; mode_in = 2'd2; tx = 32'h0F0F; slv_mode = 2'd2; loop = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    t0 = cyc;
    for (int i = 0; i < 19; i++) step();
    check("rst_mid.busy_before", 32'(busy_m), 32'd1);
    Reset = 1'b1;
    #1;
    check("rst_mid.ss_n", 32'(ss_n_m), 32'd1);
    check("rst_mid.sclk", 32'(sclk_m), 32'd0);
    check("rst_mid.busy", 32'(busy_m), 32'd0);
    check("rst_mid.rx",   rx_m, 32'd0);
    check("rst_mid.mosi", 32'(mosi_m), 32'd0);
    step(); step();
    Reset = 1'b0;
    step();
    run_frame(0, 2'd2, 32'h6E21, 32'hB00B, 1'b0, 0, 0, "post_rst");

    // Start held through two back-to-back frames on the CLK_DIV=1 instance.
    sel = 2; loop = 1'b1; mode_in = 2'd0; slv_mode = 2'd0; tx = 32'h3C96;
    step();
    fr0 = frames;
    start = 1'b1;
    step();
    t0 = cyc;
    mode_in = 2'd1; slv_mode = 2'd1; tx = 32'hC3A5;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (done_m) begin ok = 1; break; end
    end
    check("b2b.done1_seen", 32'(ok), 32'd1);
    d1 = cyc;
    check("b2b.latency1", 32'(d1 - t0), 32'd34);
    check("b2b.rx1", rx_m, 32'h3C96);
    step();
    start = 1'b0;
    check("b2b.reaccept_busy", 32'(busy_m), 32'd1);
    check("b2b.reaccept_ss_n", 32'(ss_n_m), 32'd0);
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (done_m) begin ok = 1; break; end
    end
    check("b2b.done2_seen", 32'(ok), 32'd1);
    d2 = cyc;
    check("b2b.done_spacing", 32'(d2 - d1), 32'd35);
    check("b2b.rx2", rx_m, 32'hC3A5);
    step();
    check("b2b.gap", 32'(last_gap), 32'd1);
    check("b2b.mosi1", slv_rx_arr[fr0 % 64], 32'h3C96);
    check("b2b.mosi2", slv_rx_arr[(fr0 + 1) % 64], 32'hC3A5);

    run_frame(1, 2'd1, 32'h5A, 32'h0, 1'b1, 0, 0, "f8_m1_loop");

    for (int i = 0; i < 9; i++) begin
      run_frame($urandom_range(0, 2), 2'($urandom_range(0, 3)), $urandom, $urandom,
                1'($urandom_range(0, 1)), 0, 0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
